alu_reg_file: RTL and testbench
===============================

Name: alu_reg_file

Overview:
- Architectural register file for the 8-bit emulator datapath, directly upstream and downstream of the ALU.
- Two combinational read ports drive the ALU operand inputs (ra_in, rb_in).
- A primary write port takes the ALU result or load data. A dedicated carry write port captures the ALU carry/shift-out byte into a fixed carry register.
- A one-bit zero-flag register latches the ALU zero output for later branches.

Parameters:
- REG_WIDTH, 8, data width of every register and port.
- ADDR_WIDTH, 3, register index width; NUM_REGS = 2**ADDR_WIDTH.
- CAR_IDX, 7, index of the register written by the carry port; must be < NUM_REGS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ra_addr  input  ADDR_WIDTH  read port A index
- rb_addr  input  ADDR_WIDTH  read port B index
- ra_out  output  REG_WIDTH  register[ra_addr], feeds ALU ra_in
- rb_out  output  REG_WIDTH  register[rb_addr], feeds ALU rb_in
- wr_en  input  1  primary write enable
- wr_addr  input  ADDR_WIDTH  primary write index
- wr_data  input  REG_WIDTH  primary write data (ALU res_out or load data)
- car_en  input  1  carry write enable
- car_data  input  REG_WIDTH  carry data (ALU car_out, raw two's-complement bits)
- zero_en  input  1  zero-flag capture enable
- zero_in  input  1  ALU zero output
- zero_q  output  1  latched zero flag
- car_q  output  REG_WIDTH  direct view of register[CAR_IDX]

Behaviour:
- Reset: rst_n low asynchronously clears all NUM_REGS registers and zero_q to 0, without waiting for a clock edge.
  - ra_out, rb_out and car_q read 0 while reset is held.
  - Reset asserted mid-write discards that write.
  - Release is synchronous in effect: the first write lands on the first rising edge with rst_n high.
- Reads:
  - Combinational, zero latency.
  - ra_out/rb_out follow address changes within the same cycle.
  - Both ports may read the same index.
- Primary write: on the rising edge with wr_en=1, register[wr_addr] <= wr_data. Every index, including 0 and CAR_IDX, is writable.
- Carry write: on the rising edge with car_en=1, register[CAR_IDX] <= car_data. Stored verbatim, e.g. -1 stored as 8'hFF.
- Write collision: wr_en=1, car_en=1 and wr_addr==CAR_IDX in the same cycle: the primary write wins, carry data is dropped. If wr_addr differs, both writes commit in the same edge.
- Zero flag: on the rising edge with zero_en=1, zero_q <= zero_in; otherwise it holds.
- Read-during-write: without the optional feature, reads return the pre-edge value; the new value is visible the cycle after the edge.
- Enables low: no state change. wr_addr/wr_data/car_data are don't-care.
- No X propagation from unwritten registers: all registers are reset-defined.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: read ports forward write data in the same cycle.
  - If wr_en=1 and ra_addr==wr_addr, ra_out=wr_data. Same rule for rb.
  - Else if car_en=1 and the read address == CAR_IDX, the output = car_data.
  - Primary-over-carry priority matches the write collision rule.
  - car_q forwards likewise.
- Undefined: no forwarding; pure register reads as above.

Test Plan:
- Hold rst_n=0, then pulse clk with wr_en=1, wr_addr=2, wr_data=8'h5A -> ra_out (ra_addr=2) stays 8'h00. After release, the same write gives ra_out=8'h5A next cycle.
- Write reg3=8'h7F, reg4=8'h80 on consecutive edges; ra_addr=3, rb_addr=4 -> ra_out=8'h7F, rb_out=8'h80. ra_addr=rb_addr=4 -> both 8'h80.
- car_en=1, car_data=8'hFF, wr_en=0 -> car_q=8'hFF and ra_out (ra_addr=7)=8'hFF after the edge. Then wr_en=1, wr_addr=7, wr_data=8'h11 with car_en=1, car_data=8'h01 on the same edge -> car_q=8'h11.
- wr_en=1, wr_addr=1, wr_data=8'h22 and car_en=1, car_data=8'h01 on the same edge -> reg1=8'h22, car_q=8'h01.
- zero_en=1, zero_in=1 -> zero_q=1. Next cycle zero_en=0, zero_in=0 -> zero_q holds 1. Async rst_n pulse between edges -> zero_q=0 immediately.
- Read-during-write with reg5=8'h10, write 8'h20 to reg5 with ra_addr=5:
  - Without REGFILE_BYPASS_EN: ra_out=8'h10 before the edge.
  - With REGFILE_BYPASS_EN: ra_out=8'h20 in the same cycle.

Source files
------------

// File: rtl/alu_reg_file.sv
// rtl/alu_reg_file.sv - ALU register file: 2 comb read ports, primary + carry write, zero flag
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports and car_q.
module alu_reg_file #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CAR_IDX    = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    output logic [REG_WIDTH-1:0]  ra_out,
    output logic [REG_WIDTH-1:0]  rb_out,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [REG_WIDTH-1:0]  wr_data,
    input  logic                  car_en,
    input  logic [REG_WIDTH-1:0]  car_data,
    input  logic                  zero_en,
    input  logic                  zero_in,
    output logic                  zero_q,
    output logic [REG_WIDTH-1:0]  car_q
);

    localparam int                    NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CAR_ADDR = ADDR_WIDTH'(CAR_IDX);

    logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
    logic [REG_WIDTH-1:0] regs_d [NUM_REGS];
    logic                 zero_d;

    // Primary write is applied last so it overrides the carry write on a collision.
    always_comb begin
        regs_d = regs_q;
        if (car_en) begin
            regs_d[CAR_ADDR] = car_data;
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
        zero_d = zero_en ? zero_in : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            zero_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            zero_q <= zero_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // regs_d already holds the next state with write priority resolved; gate on reset so
    // forwarded data never shows while the array is held clear.
    always_comb begin
        ra_out = '0;
        rb_out = '0;
        car_q  = '0;
        if (rst_n) begin
            ra_out = regs_d[ra_addr];
            rb_out = regs_d[rb_addr];
            car_q  = regs_d[CAR_ADDR];
        end
    end
`else
    always_comb begin
        ra_out = regs_q[ra_addr];
        rb_out = regs_q[rb_addr];
        car_q  = regs_q[CAR_ADDR];
    end
`endif

endmodule

// File: tb/tb_alu_reg_file.sv
// tb/tb_alu_reg_file.sv - directed self-checking bench for alu_reg_file
module tb_alu_reg_file;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ra_addr, rb_addr, wr_addr;
    logic [7:0] ra_out, rb_out, wr_data, car_data, car_q;
    logic       wr_en, car_en, zero_en, zero_in, zero_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .ra_out   (ra_out),
        .rb_out   (rb_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .car_en   (car_en),
        .car_data (car_data),
        .zero_en  (zero_en),
        .zero_in  (zero_in),
        .zero_q   (zero_q),
        .car_q    (car_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        car_en  = 1'b0;
        zero_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ra_addr = 3'd2; rb_addr = 3'd7;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
        tick();
        checks++; if (ra_out !== 8'h00) begin failures++; $display("FAIL reset_ra got=%h exp=00", ra_out); end
        checks++; if (rb_out !== 8'h00) begin failures++; $display("FAIL reset_rb got=%h exp=00", rb_out); end
        checks++; if (car_q !== 8'h00) begin failures++; $display("FAIL reset_car got=%h exp=00", car_q); end
        checks++; if (zero_q !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero_q); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (ra_out !== 8'h5A) begin failures++; $display("FAIL release_write got=%h exp=5A", ra_out); end
    endtask

    task automatic test_reads();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h7F; tick();
        wr_addr = 3'd4; wr_data = 8'h80; tick();
        wr_addr = 3'd0; wr_data = 8'hA5; tick();
        idle();
        ra_addr = 3'd3; rb_addr = 3'd4; #1;
        checks++; if (ra_out !== 8'h7F) begin failures++; $display("FAIL read_ra3 got=%h exp=7F", ra_out); end
        checks++; if (rb_out !== 8'h80) begin failures++; $display("FAIL read_rb4 got=%h exp=80", rb_out); end
        ra_addr = 3'd4; #1;
        checks++; if (ra_out !== 8'h80 || rb_out !== 8'h80) begin failures++; $display("FAIL read_same got=%h/%h exp=80/80", ra_out, rb_out); end
        ra_addr = 3'd0; rb_addr = 3'd6; #1;
        checks++; if (ra_out !== 8'hA5) begin failures++; $display("FAIL read_reg0 got=%h exp=A5", ra_out); end
        checks++; if (rb_out !== 8'h00) begin failures++; $display("FAIL read_unwritten got=%h exp=00", rb_out); end
    endtask

    task automatic test_carry();
        car_en = 1'b1; car_data = 8'hFF; tick();
        idle();
        ra_addr = 3'd7; #1;
        checks++; if (car_q !== 8'hFF) begin failures++; $display("FAIL carry_q got=%h exp=FF", car_q); end
        checks++; if (ra_out !== 8'hFF) begin failures++; $display("FAIL carry_ra7 got=%h exp=FF", ra_out); end
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h11;
        car_en = 1'b1; car_data = 8'h01; tick();
        idle(); #1;
        checks++; if (car_q !== 8'h11) begin failures++; $display("FAIL collision got=%h exp=11", car_q); end
    endtask

    task automatic test_dual_write();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h22;
        car_en = 1'b1; car_data = 8'h01; tick();
        idle();
        ra_addr = 3'd1; #1;
        checks++; if (ra_out !== 8'h22) begin failures++; $display("FAIL dual_reg1 got=%h exp=22", ra_out); end
        checks++; if (car_q !== 8'h01) begin failures++; $display("FAIL dual_car got=%h exp=01", car_q); end
    endtask

    task automatic test_enables_low();
        wr_addr = 3'd1; wr_data = 8'hEE; car_data = 8'hDD; zero_in = 1'b1;
        tick();
        ra_addr = 3'd1; #1;
        checks++; if (ra_out !== 8'h22 || car_q !== 8'h01 || zero_q !== 1'b0) begin
            failures++; $display("FAIL enables_low got=%h/%h/%b exp=22/01/0", ra_out, car_q, zero_q);
        end
    endtask

    task automatic test_zero();
        zero_en = 1'b1; zero_in = 1'b1; tick();
        checks++; if (zero_q !== 1'b1) begin failures++; $display("FAIL zero_set got=%b exp=1", zero_q); end
        zero_en = 1'b0; zero_in = 1'b0; tick();
        checks++; if (zero_q !== 1'b1) begin failures++; $display("FAIL zero_hold got=%b exp=1", zero_q); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (zero_q !== 1'b0) begin failures++; $display("FAIL zero_async got=%b exp=0", zero_q); end
        checks++; if (car_q !== 8'h00) begin failures++; $display("FAIL car_async got=%h exp=00", car_q); end
        rst_n = 1'b1;
    endtask

    task automatic test_rdw();
        logic [7:0] exp_same;
        idle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h10; tick();
        wr_data = 8'h20; ra_addr = 3'd5; #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 8'h20;
`else
        exp_same = 8'h10;
`endif
        checks++; if (ra_out !== exp_same) begin failures++; $display("FAIL rdw_same got=%h exp=%h", ra_out, exp_same); end
        tick();
        idle(); #1;
        checks++; if (ra_out !== 8'h20) begin failures++; $display("FAIL rdw_after got=%h exp=20", ra_out); end
        car_en = 1'b1; car_data = 8'h3C; rb_addr = 3'd7; #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 8'h3C;
`else
        exp_same = 8'h00;
`endif
        checks++; if (car_q !== exp_same || rb_out !== exp_same) begin
            failures++; $display("FAIL rdw_car got=%h/%h exp=%h", car_q, rb_out, exp_same);
        end
        tick();
        idle(); #1;
        checks++; if (car_q !== 8'h3C) begin failures++; $display("FAIL rdw_car_after got=%h exp=3C", car_q); end
    endtask

    initial begin
        rst_n = 1'b0; ra_addr = '0; rb_addr = '0; wr_addr = '0;
        wr_data = '0; car_data = '0; zero_in = 1'b0;
        idle();
        test_reset();
        test_reads();
        test_carry();
        test_dual_write();
        test_enables_low();
        test_zero();
        test_rdw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
